usb_stream_arbiter: RTL
=======================

Name: usb_stream_arbiter

Overview:
- Drains up to NUM_SRC 32-bit readout FIFOs (tlu_master-style FIFO_READ/FIFO_EMPTY/FIFO_DATA) into the FX2 slave-FIFO stream interface, 16 bits per STREAM_CLK write.
- Arbitration between sources is round-robin.
- Replaces the loopback counter generator on the stream side.
- Handles FX2 full/ready flow control and commits short packets via PKTEND after an idle timeout.

Parameters:
- NUM_SRC, 2, number of 32-bit FIFO sources (1..8).
- PKT_WORDS, 256, 16-bit words per full FX2 packet; FX2 auto-commits at this size.
- TIMEOUT, 4096, idle STREAM_CLK cycles before a partial packet is committed.
- FIFO_ADDR, 2'b10, constant FX2 endpoint address.

Ports:
- STREAM_CLK  in  1  stream clock; all logic on rising edge.
- STREAM_RST_N  in  1  synchronous active-low reset.
- ENABLE  in  1  permits new source reads.
- SRC_FIFO_EMPTY  in  NUM_SRC  per-source empty flag.
- SRC_FIFO_READ  out  NUM_SRC  per-source one-cycle read strobe.
- SRC_FIFO_DATA  in  32*NUM_SRC  source i occupies [32i+31:32i]; valid the cycle after its read strobe.
- STREAM_FULL_N  in  1  FX2 full flag, active low (1 = space).
- STREAM_FX2RDY  in  1  FX2 ready.
- USB_STREAM_FIFOADDR  out  2  = FIFO_ADDR.
- USB_STREAM_SLWR_N  out  1  write strobe, active low.
- USB_STREAM_PKTEND_N  out  1  packet commit, active low.
- USB_STREAM_DATA_OUT  out  16  write data.
- BUSY  out  1  high when state != IDLE or the packet count is nonzero.

Behaviour:
- Reset (STREAM_RST_N=0 at edge), including mid-operation:
  - state IDLE; RR pointer 0; pkt_cnt 0; idle_cnt 0; holding register 0.
  - SRC_FIFO_READ 0, USB_STREAM_DATA_OUT 0, BUSY 0.
  - USB_STREAM_SLWR_N and USB_STREAM_PKTEND_N 1 while in reset.
  - A word already held is discarded.
- States: IDLE, READ, LATCH, LOW, HIGH, FLUSH.
- IDLE:
  - Condition: ENABLE=1, STREAM_FX2RDY=1 and any source non-empty.
  - On that condition: grant the first non-empty source at or after the RR pointer (wrapping) and go to READ.
  - Otherwise, if idle_cnt==TIMEOUT-1 and pkt_cnt!=0, go to FLUSH.
- READ: SRC_FIFO_READ[grant]=1 for exactly this cycle (registered output); go to LATCH.
- LATCH: capture the granted SRC_FIFO_DATA slice into the 32-bit holding register; RR pointer = grant+1 mod NUM_SRC; go to LOW.
- LOW: data = hold[15:0]. USB_STREAM_SLWR_N = ~(STREAM_FULL_N & STREAM_FX2RDY), combinational from state and flags. If written, go to HIGH; else stay, holding data stable.
- HIGH: same as LOW with hold[31:16]. If written, go to IDLE.
- FLUSH: USB_STREAM_PKTEND_N = ~STREAM_FULL_N. When asserted, clear pkt_cnt and idle_cnt and go to IDLE; else stay.
- pkt_cnt:
  - +1 on every write (SLWR_N=0 at edge).
  - A write with pkt_cnt==PKT_WORDS-1 sets it to 0; no PKTEND is issued for full packets.
  - A full packet is always an even number of halves; LOW/HIGH pairs never straddle a flush.
- idle_cnt:
  - Increments in IDLE when no read is started; saturates at TIMEOUT-1.
  - Cleared on any write and when leaving IDLE.
  - Timeout is evaluated only in IDLE, so a pending half-word is always written before a flush.
- ENABLE=0 mid-word: the current word completes (LOW and HIGH both written); no new READ starts. Timeout flush still occurs.
- STREAM_FULL_N=0: no data lost, no duplicate write. SLWR_N/PKTEND_N stay 1 until the flag returns to 1.
- STREAM_FX2RDY=0: blocks new grants and writes; FLUSH is not gated by it.
- Throughput: 4 cycles per 32-bit word with no stall (READ, LATCH, LOW, HIGH) plus 1 IDLE cycle between words.
- Latency: grant to first SLWR_N low is 2 cycles.
- A source going empty between grant and READ is not possible, since only this block reads the sources.

Test Plan:
- One source, one word 0xDEADBEEF, FULL_N=1, FX2RDY=1 → READ strobe 1 cycle; writes 0xBEEF then 0xDEAD on consecutive cycles. After 4096 idle cycles, PKTEND_N low for exactly 1 cycle; BUSY drops.
- Both sources hold 3 words each (src0 0x0000000k, src1 0x1000000k) → output order src0,src1,src0,src1,src0,src1; no source granted twice in a row while the other is non-empty.
- 128 words continuously → 256 writes; pkt_cnt wraps to 0 on the 256th write; no PKTEND_N asserted.
- STREAM_FULL_N forced 0 for 10 cycles while in HIGH → SLWR_N held 1, data held 0xDEAD. Exactly one write of 0xDEAD after release; next word follows correctly.
- STREAM_RST_N pulsed low for 1 cycle while in LOW → all outputs at reset values the next cycle; held word dropped; following words stream normally.
- ENABLE dropped in LOW with 2 more words queued → current word completes both halves; queued words remain unread (SRC_FIFO_READ stays 0); timeout flush commits the partial packet.

Source files
------------

// File: rtl/usb_stream_arbiter_if.sv
// FX2 slave-FIFO stream bundle: flow-control flags in, write strobe, commit and data out.
// The arbiter takes the master modport and the FX2 (or its model) takes the slave modport.
interface usb_stream_arbiter_if;
    logic        STREAM_FULL_N;
    logic        STREAM_FX2RDY;
    logic [1:0]  USB_STREAM_FIFOADDR;
    logic        USB_STREAM_SLWR_N;
    logic        USB_STREAM_PKTEND_N;
    logic [15:0] USB_STREAM_DATA_OUT;

    modport master (
        input  STREAM_FULL_N,
        input  STREAM_FX2RDY,
        output USB_STREAM_FIFOADDR,
        output USB_STREAM_SLWR_N,
        output USB_STREAM_PKTEND_N,
        output USB_STREAM_DATA_OUT
    );

    modport slave (
        output STREAM_FULL_N,
        output STREAM_FX2RDY,
        input  USB_STREAM_FIFOADDR,
        input  USB_STREAM_SLWR_N,
        input  USB_STREAM_PKTEND_N,
        input  USB_STREAM_DATA_OUT
    );
endinterface

// File: rtl/usb_stream_arbiter.sv
// Round-robin drain of NUM_SRC 32-bit readout FIFOs into the FX2 slave FIFO, 16 bits per write,
// with idle-timeout commit of short packets through PKTEND.
module usb_stream_arbiter #(
    parameter int          NUM_SRC   = 2,
    parameter int          PKT_WORDS = 256,
    parameter int          TIMEOUT   = 4096,
    parameter logic [1:0]  FIFO_ADDR = 2'b10
) (
    input  logic                   STREAM_CLK,
    input  logic                   STREAM_RST_N,
    input  logic                   ENABLE,
    input  logic [NUM_SRC-1:0]     SRC_FIFO_EMPTY,
    output logic [NUM_SRC-1:0]     SRC_FIFO_READ,
    input  logic [32*NUM_SRC-1:0]  SRC_FIFO_DATA,
    usb_stream_arbiter_if.master   stream,
    output logic                   BUSY
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [PTR_W-1:0] LAST_SRC = PTR_W'(NUM_SRC - 1);
    localparam logic [CNT_W-1:0] PKT_LAST = CNT_W'(PKT_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, READ, LATCH, LOW, HIGH, FLUSH} state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W-1:0]   pick;
    logic               any_ready;
    logic [NUM_SRC-1:0] read_onehot;
    logic [31:0]        src_word;
    logic [31:0]        hold;
    logic [CNT_W-1:0]   pkt_cnt;
    logic [TO_W-1:0]    idle_cnt;
    logic               start;
    logic               wr;
    logic               pkt_commit;
    logic [15:0]        data_mux;
    int                 best;
    int                 off;

    // Pick the non-empty source with the smallest rotation distance from the RR pointer.
    always_comb begin
        pick        = '0;
        any_ready   = 1'b0;
        best        = NUM_SRC;
        off         = 0;
        read_onehot = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            off = j - int'(rr_ptr);
            if (off < 0) off = off + NUM_SRC;
            if (!SRC_FIFO_EMPTY[j] && off < best) begin
                best      = off;
                pick      = PTR_W'(j);
                any_ready = 1'b1;
            end
        end
        for (int j = 0; j < NUM_SRC; j++) begin
            read_onehot[j] = (pick == PTR_W'(j));
        end
    end

    always_comb begin
        src_word = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (grant == PTR_W'(j)) src_word = SRC_FIFO_DATA[32*j +: 32];
        end
    end

    always_ff @(posedge STREAM_CLK) begin
        if (!STREAM_RST_N) state <= IDLE;
        else               state <= state_next;
    end

    // Strobes are gated by reset so a word in flight is never written while reset is held.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        wr         = 1'b0;
        pkt_commit = 1'b0;
        data_mux   = 16'h0000;
        case (state)
            IDLE: begin
                if (ENABLE && stream.STREAM_FX2RDY && any_ready) begin
                    start      = 1'b1;
                    state_next = READ;
                end else if (idle_cnt == TO_LAST && pkt_cnt != '0) begin
                    state_next = FLUSH;
                end
            end
            READ:  state_next = LATCH;
            LATCH: state_next = LOW;
            LOW: begin
                data_mux = hold[15:0];
                wr       = stream.STREAM_FULL_N & stream.STREAM_FX2RDY & STREAM_RST_N;
                if (wr) state_next = HIGH;
            end
            HIGH: begin
                data_mux = hold[31:16];
                wr       = stream.STREAM_FULL_N & stream.STREAM_FX2RDY & STREAM_RST_N;
                if (wr) state_next = IDLE;
            end
            FLUSH: begin
                pkt_commit = stream.STREAM_FULL_N & STREAM_RST_N;
                if (pkt_commit) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge STREAM_CLK) begin
        if (!STREAM_RST_N) begin
            rr_ptr        <= '0;
            grant         <= '0;
            hold          <= '0;
            pkt_cnt       <= '0;
            idle_cnt      <= '0;
            SRC_FIFO_READ <= '0;
        end else begin
            SRC_FIFO_READ <= start ? read_onehot : '0;
            if (start) grant <= pick;

            if (state == LATCH) begin
                hold   <= src_word;
                rr_ptr <= (grant == LAST_SRC) ? '0 : grant + PTR_W'(1);
            end

            // FX2 auto-commits a full packet, so the count simply wraps on its last word.
            if (wr)              pkt_cnt <= (pkt_cnt == PKT_LAST) ? '0 : pkt_cnt + CNT_W'(1);
            else if (pkt_commit) pkt_cnt <= '0;

            if (wr || pkt_commit || (state == IDLE && state_next != IDLE))
                idle_cnt <= '0;
            else if (state == IDLE && idle_cnt != TO_LAST)
                idle_cnt <= idle_cnt + TO_W'(1);
        end
    end

    assign stream.USB_STREAM_FIFOADDR = FIFO_ADDR;
    assign stream.USB_STREAM_SLWR_N   = ~wr;
    assign stream.USB_STREAM_PKTEND_N = ~pkt_commit;
    assign stream.USB_STREAM_DATA_OUT = STREAM_RST_N ? data_mux : 16'h0000;
    assign BUSY = STREAM_RST_N & ((state != IDLE) | (pkt_cnt != '0));

endmodule
